// File: rtl/tetris_sched_pkg.sv
// Shared definitions for the drop scheduler: field-operation codes, lifecycle
// FSM states and the FALL-state operation priority helper.
package tetris_sched_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_NOP   = 3'd0;
  localparam logic [OP_W-1:0] OP_LEFT  = 3'd1;
  localparam logic [OP_W-1:0] OP_RIGHT = 3'd2;
  localparam logic [OP_W-1:0] OP_ROT   = 3'd3;
  localparam logic [OP_W-1:0] OP_DOWN  = 3'd4;
  localparam logic [OP_W-1:0] OP_SPAWN = 3'd5;
  localparam logic [OP_W-1:0] OP_LOCK  = 3'd6;
  localparam logic [OP_W-1:0] OP_CLEAR = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SPAWN = 3'd1,
    ST_FALL  = 3'd2,
    ST_LOCK  = 3'd3,
    ST_CLEAR = 3'd4,
    ST_OVER  = 3'd5
  } sched_state_t;

  // Gravity wins over player input; rotation beats lateral moves.
  function automatic logic [OP_W-1:0] pick_fall_op(input logic down, input logic rot,
                                                   input logic left, input logic right);
    logic [OP_W-1:0] op;
    if (down) begin
      op = OP_DOWN;
    end else if (rot) begin
      op = OP_ROT;
    end else if (left) begin
      op = OP_LEFT;
    end else if (right) begin
      op = OP_RIGHT;
    end else begin
      op = OP_NOP;
    end
    return op;
  endfunction

endpackage

// File: rtl/gravity_timer.sv
// Gravity tick divider. Counts tick pulses while enabled and fires once the
// count reaches the active limit (soft-drop or normal), then restarts from 0.
module gravity_timer #(
  parameter int unsigned GRAVITY_DIV = 10,
  parameter int unsigned SOFT_DIV    = 1,
  parameter int unsigned CNT_W       = 8
) (
  input  logic clock_b,
  input  logic resetn,
  input  logic enable,
  input  logic tick,
  input  logic soft_drop,
  input  logic clear,
  output logic fire
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] limit;

  // Limit is re-evaluated every tick, so a switch to soft drop with a high
  // count fires on the very next tick (>= rather than ==).
  assign limit = soft_drop ? CNT_W'(SOFT_DIV) : CNT_W'(GRAVITY_DIV);
  assign fire  = enable & tick & (count >= limit);

  // Divider counter: cleared on spawn, advanced only by enabled ticks.
  always_ff @(posedge clock_b or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && tick) begin
      count <= fire ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/drop_scheduler.sv
// Piece lifecycle sequencer: spawn, fall, lock, clear. Issues one field op at a
// time over op_valid/op_ready and arbitrates gravity against player requests.
// Optional feature macro: SCHED_PAUSE_EN adds a pause input that freezes
// gravity and new offers while in FALL.
module drop_scheduler
  import tetris_sched_pkg::*;
#(
  parameter int unsigned GRAVITY_DIV = 10,
  parameter int unsigned SOFT_DIV    = 1,
  parameter int unsigned CNT_W       = 8
) (
  input  logic            clock_b,
  input  logic            resetn,
  input  logic            tick,
  input  logic            start,
  input  logic            soft_drop,
  input  logic            move_left,
  input  logic            move_right,
  input  logic            rotate,
`ifdef SCHED_PAUSE_EN
  input  logic            pause,
`endif
  output logic            op_valid,
  output logic [OP_W-1:0] op_code,
  input  logic            op_ready,
  input  logic            op_blocked,
  output logic            game_over
);

  sched_state_t state;

  logic paused;
  logic xfer;
  logic grav_en;
  logic grav_clr;
  logic grav_fire;
  logic lock_entry;

  logic down_q, rot_q, left_q, right_q;
  logic down_d, rot_d, left_d, right_d;
  logic fall_any;
  logic [OP_W-1:0] fall_op;

`ifdef SCHED_PAUSE_EN
  assign paused = pause;
`else
  assign paused = 1'b0;
`endif

  assign xfer       = op_valid & op_ready;
  assign grav_en    = (state == ST_FALL) & ~paused;
  assign grav_clr   = xfer & (state == ST_SPAWN) & ~op_blocked;
  assign lock_entry = xfer & (state == ST_FALL) & (op_code == OP_DOWN) & op_blocked;

  gravity_timer #(
    .GRAVITY_DIV (GRAVITY_DIV),
    .SOFT_DIV    (SOFT_DIV),
    .CNT_W       (CNT_W)
  ) u_gravity_timer (
    .clock_b   (clock_b),
    .resetn    (resetn),
    .enable    (grav_en),
    .tick      (tick),
    .soft_drop (soft_drop),
    .clear     (grav_clr),
    .fire      (grav_fire)
  );

  // Pending-request next state: transfer clears its own bit, a fresh pulse
  // re-arms it, spawn drops stale gravity, lock entry discards everything.
  always_comb begin
    down_d  = down_q;
    rot_d   = rot_q;
    left_d  = left_q;
    right_d = right_q;
    if (xfer) begin
      unique case (op_code)
        OP_DOWN:  down_d  = 1'b0;
        OP_ROT:   rot_d   = 1'b0;
        OP_LEFT:  left_d  = 1'b0;
        OP_RIGHT: right_d = 1'b0;
        default:  ;
      endcase
    end
    if (grav_fire)  down_d  = 1'b1;
    if (rotate)     rot_d   = 1'b1;
    if (move_left)  left_d  = 1'b1;
    if (move_right) right_d = 1'b1;
    if (grav_clr) begin
      down_d = 1'b0;
    end
    if (lock_entry) begin
      down_d  = 1'b0;
      rot_d   = 1'b0;
      left_d  = 1'b0;
      right_d = 1'b0;
    end
  end

  // Offer decisions see this cycle's new requests, giving one-cycle latency.
  assign fall_any = down_d | rot_d | left_d | right_d;
  assign fall_op  = pick_fall_op(down_d, rot_d, left_d, right_d);

  // Pending-request bits.
  always_ff @(posedge clock_b or negedge resetn) begin
    if (!resetn) begin
      down_q  <= 1'b0;
      rot_q   <= 1'b0;
      left_q  <= 1'b0;
      right_q <= 1'b0;
    end else begin
      down_q  <= down_d;
      rot_q   <= rot_d;
      left_q  <= left_d;
      right_q <= right_d;
    end
  end

  // Lifecycle FSM with registered handshake outputs. A new op is only chosen
  // while nothing is offered, so op_code is frozen from offer until transfer
  // and at least one idle cycle separates consecutive ops.
  always_ff @(posedge clock_b or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      op_valid  <= 1'b0;
      op_code   <= OP_NOP;
      game_over <= 1'b0;
    end else if (xfer) begin
      op_valid <= 1'b0;
      op_code  <= OP_NOP;
      unique case (state)
        ST_SPAWN: begin
          state     <= op_blocked ? ST_OVER : ST_FALL;
          game_over <= op_blocked;
        end
        ST_FALL: begin
          // Blocked lateral/rotate moves are simply dropped.
          if (op_code == OP_DOWN && op_blocked) begin
            state <= ST_LOCK;
          end
        end
        ST_LOCK:  state <= ST_CLEAR;
        ST_CLEAR: state <= ST_SPAWN;
        default:  ;
      endcase
    end else if (!op_valid) begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_SPAWN;
          end
        end
        ST_OVER: begin
          if (start) begin
            state     <= ST_SPAWN;
            game_over <= 1'b0;
          end
        end
        ST_SPAWN: begin
          op_valid <= 1'b1;
          op_code  <= OP_SPAWN;
        end
        ST_FALL: begin
          if (!paused && fall_any) begin
            op_valid <= 1'b1;
            op_code  <= fall_op;
          end
        end
        ST_LOCK: begin
          op_valid <= 1'b1;
          op_code  <= OP_LOCK;
        end
        ST_CLEAR: begin
          op_valid <= 1'b1;
          op_code  <= OP_CLEAR;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_drop_scheduler.sv
// Bench for drop_scheduler: directed scenarios, a cycle-level reference model
// compared every cycle, and hand-computed transfer-sequence expectations.
module tb_drop_scheduler;

  localparam int GDIV = 10;
  localparam int SDIV = 1;

  localparam int C_NOP = 0, C_LEFT = 1, C_RIGHT = 2, C_ROT = 3;
  localparam int C_DOWN = 4, C_SPAWN = 5, C_LOCK = 6, C_CLEAR = 7;
  localparam int M_IDLE = 0, M_SPAWN = 1, M_FALL = 2, M_LOCK = 3, M_CLEAR = 4, M_OVER = 5;

  logic clock_b = 1'b0;
  logic resetn = 1'b0;
  logic tick = 1'b0, start = 1'b0, soft_drop = 1'b0;
  logic move_left = 1'b0, move_right = 1'b0, rotate = 1'b0, pause = 1'b0;
  logic op_ready = 1'b1, op_blocked = 1'b0;
  logic op_valid, game_over;
  logic [2:0] op_code;

  drop_scheduler #(
    .GRAVITY_DIV (GDIV),
    .SOFT_DIV    (SDIV),
    .CNT_W       (8)
  ) dut (
    .clock_b    (clock_b),
    .resetn     (resetn),
    .tick       (tick),
    .start      (start),
    .soft_drop  (soft_drop),
    .move_left  (move_left),
    .move_right (move_right),
    .rotate     (rotate),
`ifdef SCHED_PAUSE_EN
    .pause      (pause),
`endif
    .op_valid   (op_valid),
    .op_code    (op_code),
    .op_ready   (op_ready),
    .op_blocked (op_blocked),
    .game_over  (game_over)
  );

  always #5 clock_b = ~clock_b;

  int n_cmp = 0;
  int n_bad = 0;
  int xlog[$];

  // Reference model: game state, divider count, pending requests by priority rank.
  int m_state = M_IDLE;
  bit m_valid = 1'b0;
  int m_code  = C_NOP;
  bit m_over  = 1'b0;
  int m_cnt   = 0;
  bit m_req[4];
  int rank_code[4] = '{C_DOWN, C_ROT, C_LEFT, C_RIGHT};

  task automatic check(string name, int got, int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE;
    m_valid = 1'b0;
    m_code  = C_NOP;
    m_over  = 1'b0;
    m_cnt   = 0;
    foreach (m_req[r]) m_req[r] = 1'b0;
  endtask

  task automatic model_step();
    bit xfer, fire;
    int code;
    xfer = m_valid && op_ready;
    code = m_code;
    fire = 1'b0;
    if (m_state == M_FALL && !pause && tick) begin
      if (m_cnt >= (soft_drop ? SDIV : GDIV)) begin
        fire  = 1'b1;
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
    if (xfer) foreach (rank_code[r]) if (rank_code[r] == code) m_req[r] = 1'b0;
    if (fire) m_req[0] = 1'b1;
    if (rotate) m_req[1] = 1'b1;
    if (move_left) m_req[2] = 1'b1;
    if (move_right) m_req[3] = 1'b1;
    if (xfer && m_state == M_SPAWN && !op_blocked) begin
      m_cnt    = 0;
      m_req[0] = 1'b0;
    end
    if (xfer && m_state == M_FALL && code == C_DOWN && op_blocked)
      foreach (m_req[r]) m_req[r] = 1'b0;
    if (xfer) begin
      m_valid = 1'b0;
      m_code  = C_NOP;
      if (m_state == M_SPAWN) begin
        m_state = op_blocked ? M_OVER : M_FALL;
        m_over  = op_blocked;
      end else if (m_state == M_FALL && code == C_DOWN && op_blocked) begin
        m_state = M_LOCK;
      end else if (m_state == M_LOCK) begin
        m_state = M_CLEAR;
      end else if (m_state == M_CLEAR) begin
        m_state = M_SPAWN;
      end
    end else if (!m_valid) begin
      if ((m_state == M_IDLE || m_state == M_OVER) && start) begin
        m_state = M_SPAWN;
        m_over  = 1'b0;
      end else if (m_state == M_SPAWN) begin
        m_valid = 1'b1; m_code = C_SPAWN;
      end else if (m_state == M_LOCK) begin
        m_valid = 1'b1; m_code = C_LOCK;
      end else if (m_state == M_CLEAR) begin
        m_valid = 1'b1; m_code = C_CLEAR;
      end else if (m_state == M_FALL && !pause) begin
        for (int r = 0; r < 4; r++) begin
          if (m_req[r] && !m_valid) begin
            m_valid = 1'b1;
            m_code  = rank_code[r];
          end
        end
      end
    end
  endtask

  initial begin
    foreach (m_req[r]) m_req[r] = 1'b0;
    forever begin
      @(posedge clock_b or negedge resetn);
      if (!resetn) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison against the model, plus transfer logging.
  initial begin
    forever begin
      @(negedge clock_b);
      if (op_valid && op_ready) xlog.push_back(int'(op_code));
      check($sformatf("cyc_valid@%0t", $time), int'(op_valid), int'(m_valid));
      if (m_valid) check($sformatf("cyc_code@%0t", $time), int'(op_code), m_code);
      check($sformatf("cyc_over@%0t", $time), int'(game_over), int'(m_over));
    end
  end

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clock_b);
      #1;
    end
  endtask

  task automatic do_ticks(int n);
    repeat (n) begin
      tick = 1'b1;
      cyc(1);
      tick = 1'b0;
      cyc(2);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  function automatic int count_op(int c);
    int k = 0;
    foreach (xlog[i]) if (xlog[i] == c) k++;
    return k;
  endfunction

  task automatic check_log(string name, int n, int a0, int a1, int a2, int a3);
    int exp[4];
    exp = '{a0, a1, a2, a3};
    check({name, "_len"}, xlog.size(), n);
    for (int i = 0; i < n && i < 4; i++)
      check($sformatf("%s_%0d", name, i), (i < xlog.size()) ? xlog[i] : -1, exp[i]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values
    cyc(3);
    @(negedge clock_b);
    check("rst_valid", int'(op_valid), 0);
    check("rst_code", int'(op_code), C_NOP);
    check("rst_over", int'(game_over), 0);
    cyc(1);
    resetn = 1'b1;
    cyc(2);

    // Start: exactly one SPAWN, then FALL
    pulse_start();
    cyc(6);
    check_log("spawn", 1, C_SPAWN, 0, 0, 0);
    check("spawn_over", int'(game_over), 0);

    // Request pulse in cycle N is offered in N+1
    xlog.delete();
    move_right = 1'b1;
    @(posedge clock_b);
    #1;
    move_right = 1'b0;
    @(negedge clock_b);
    check("req_lat_valid", int'(op_valid), 1);
    check("req_lat_code", int'(op_code), C_RIGHT);
    cyc(3);

    // Normal gravity: 22 ticks give two DOWNs
    xlog.delete();
    do_ticks(22);
    check("grav_downs", count_op(C_DOWN), 2);
    check("grav_len", xlog.size(), 2);

    // Soft drop: DOWN every 2 ticks
    xlog.delete();
    soft_drop = 1'b1;
    do_ticks(6);
    check("soft_downs", count_op(C_DOWN), 3);
    // Count to 7 at normal rate, then switch: fires on next tick
    soft_drop = 1'b0;
    xlog.delete();
    do_ticks(7);
    check("cnt7_downs", xlog.size(), 0);
    soft_drop = 1'b1;
    do_ticks(1);
    check_log("switch", 1, C_DOWN, 0, 0, 0);
    soft_drop = 1'b0;

    // Gravity fire with left+rotate in the same cycle: DOWN, ROT, LEFT
    do_ticks(10);
    xlog.delete();
    tick = 1'b1; move_left = 1'b1; rotate = 1'b1;
    @(posedge clock_b);
    #1;
    tick = 1'b0; move_left = 1'b0; rotate = 1'b0;
    @(negedge clock_b);
    check("prio_first_code", int'(op_code), C_DOWN);
    cyc(8);
    check_log("prio", 3, C_DOWN, C_ROT, C_LEFT, 0);

    // Held LEFT with op_ready=0; duplicate pulse absorbed
    xlog.delete();
    op_ready = 1'b0;
    move_left = 1'b1;
    cyc(1);
    move_left = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) move_left = 1'b1;
      @(negedge clock_b);
      check($sformatf("hold_valid_%0d", i), int'(op_valid), 1);
      check($sformatf("hold_code_%0d", i), int'(op_code), C_LEFT);
      @(posedge clock_b);
      #1;
      move_left = 1'b0;
    end
    op_ready = 1'b1;
    cyc(6);
    check_log("hold", 1, C_LEFT, 0, 0, 0);

    // start while falling is ignored
    xlog.delete();
    pulse_start();
    cyc(4);
    check("start_ignored", xlog.size(), 0);

    // Blocked DOWN: LOCK, CLEAR, then blocked SPAWN ends the game
    op_ready = 1'b0;
    do_ticks(11);
    xlog.delete();
    op_ready = 1'b1;
    op_blocked = 1'b1;
    cyc(10);
    op_blocked = 1'b0;
    check_log("lockseq", 4, C_DOWN, C_LOCK, C_CLEAR, C_SPAWN);
    @(negedge clock_b);
    check("over_set", int'(game_over), 1);
    xlog.delete();
    pulse_start();
    cyc(6);
    check_log("restart", 1, C_SPAWN, 0, 0, 0);
    check("over_clr", int'(game_over), 0);

    // Reset mid-offer drops op_valid immediately
    op_ready = 1'b0;
    move_right = 1'b1;
    cyc(1);
    move_right = 1'b0;
    cyc(1);
    #2;
    resetn = 1'b0;
    #1;
    check("rst_async_valid", int'(op_valid), 0);
    cyc(2);
    resetn = 1'b1;
    op_ready = 1'b1;
    cyc(1);
    xlog.delete();
    pulse_start();
    cyc(6);
    check_log("post_rst", 1, C_SPAWN, 0, 0, 0);

`ifdef SCHED_PAUSE_EN
    // Pause freezes divider and offers; requests still latch
    do_ticks(5);
    xlog.delete();
    pause = 1'b1;
    move_left = 1'b1;
    cyc(1);
    move_left = 1'b0;
    do_ticks(30);
    check("pause_quiet", xlog.size(), 0);
    pause = 1'b0;
    cyc(4);
    check_log("pause_rel", 1, C_LEFT, 0, 0, 0);
    xlog.delete();
    do_ticks(5);
    check("pause_resume_nofire", xlog.size(), 0);
    do_ticks(1);
    check_log("pause_resume_fire", 1, C_DOWN, 0, 0, 0);
`endif

    cyc(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/drop_scheduler.md
# drop_scheduler

Sequencer between player inputs, gravity timing and the playfield engine. Runs a piece lifecycle FSM (spawn, fall, lock, clear) and issues one field operation at a time over a valid/ready handshake. It also arbitrates gravity drops against left/right/rotate requests. Gravity is paced by a programmable tick divider with a soft-drop fast rate.

## Interface
- GRAVITY_DIV, 10: normal-rate limit; one drop every GRAVITY_DIV+1 ticks
- SOFT_DIV, 1: soft-drop limit; one drop every SOFT_DIV+1 ticks
- CNT_W, 8: divider counter width; both limits must be < 2^CNT_W
- clock_b  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle frame-rate pulse driving the gravity divider
- start  in  1  pulse; begins a game from IDLE or OVER
- soft_drop  in  1  level; selects SOFT_DIV
- move_left, move_right, rotate  in  1 each  one-cycle request pulses
- pause  in  1  level; present only with SCHED_PAUSE_EN
- op_valid  out  1  operation offered
- op_code  out  3  0 NOP, 1 LEFT, 2 RIGHT, 3 ROT, 4 DOWN, 5 SPAWN, 6 LOCK, 7 CLEAR
- op_ready  in  1  engine accepts the operation this cycle
- op_blocked  in  1  engine result; valid only in the transfer cycle
- game_over  out  1  high in OVER

## Operation
- Reset values: state IDLE, op_valid 0, op_code 0, game_over 0, divider 0, all pending bits 0.
- Transfer: op_valid & op_ready in the same cycle.
- After op_valid rises, op_code is held stable until transfer. Valid never drops without a transfer.
- Pending latches: move_left, move_right and rotate pulses each set their own bit in any state. A bit clears only when its op transfers. A new pulse while the bit is already set is absorbed.
- Divider counts tick pulses only in FALL.
  - Limit = soft_drop ? SOFT_DIV : GRAVITY_DIV, sampled at each tick.
  - On a tick with count < limit: count+1.
  - On a tick with count >= limit: count←0 and down_pend←1.
  - Switching to soft drop with count above SOFT_DIV fires on the next tick.
- States:
  - IDLE: no ops. start → SPAWN.
  - SPAWN: offer SPAWN.
    - Transfer with blocked=1 → OVER.
    - Transfer with blocked=0 → FALL; divider and down_pend cleared.
  - FALL: when idle, offer the highest pending op. Priority is DOWN > ROT > LEFT > RIGHT.
    - DOWN transfer with blocked=1 → LOCK.
    - Blocked LEFT/RIGHT/ROT transfers are ignored; the bit still clears.
  - LOCK: offer LOCK; transfer → CLEAR. All pending bits cleared on entry.
  - CLEAR: offer CLEAR; transfer → SPAWN.
  - OVER: game_over=1; no ops; start → SPAWN with game_over←0.
- start outside IDLE/OVER is ignored.

## Timing
- Request pulse in cycle N, FALL, handshake idle, nothing higher pending: op_valid with that op_code in cycle N+1.
- The next op may be offered in the cycle after a transfer (one op per two cycles minimum).
- Gravity tick in cycle N reaching the limit: DOWN offered in N+1, unless an op is already held, in which case after that transfer.
- State transitions take effect the cycle after the transfer.
- Reset mid-handshake: op_valid drops asynchronously and the offered op is abandoned.

## Configuration
- SCHED_PAUSE_EN defined:
  - pause port exists.
  - While pause=1 in FALL: divider frozen (ticks ignored) and no new op offered.
  - An op already offered still completes its handshake.
  - Request pulses still latch.
- SCHED_PAUSE_EN undefined: no pause port; behaviour as if pause=0.

## Structure
- Package tetris_sched_pkg: op code localparams (OP_NOP…OP_CLEAR), state encoding (ST_IDLE, ST_SPAWN, ST_FALL, ST_LOCK, ST_CLEAR, ST_OVER), 3-bit op width constant.
- Sub-module gravity_timer: the tick divider.
  - Inputs: clock_b, resetn, enable, tick, soft_drop, clear.
  - Output: one-cycle fire pulse.
  - Parameters: GRAVITY_DIV, SOFT_DIV, CNT_W.

## Test plan
- Reset, start, op_ready=1, blocked=0 always: SPAWN once, then DOWN every 11 ticks; game_over stays 0.
- soft_drop=1 in FALL: DOWN every 2 ticks. Switch with count=7 → DOWN on the next tick.
- move_left and rotate pulsed in the same cycle, with a gravity fire in the same cycle: ops issued DOWN, ROT, LEFT in order, op_ready held 1.
- op_ready=0 for 5 cycles with LEFT offered: op_code stays 1 and op_valid stays 1. A second move_left pulse meanwhile yields only one LEFT.
- DOWN with blocked=1: LOCK, then CLEAR, then SPAWN. SPAWN with blocked=1 → game_over=1. start → SPAWN again.
- With SCHED_PAUSE_EN, pause=1 for 30 ticks: no DOWN. Release: divider resumes from its frozen count. resetn low mid-offer: op_valid=0 immediately, state IDLE.
